// File: rtl/regfile_pkg.sv
// Shared helpers for the register file: port slice offsets, a log2 for
// counter sizing, and the index of the optional hard-wired zero register.
package regfile_pkg;

    localparam int ZERO_IDX = 0;

    // Low bit of read port i inside the packed address bus
    function automatic int port_addr(input int i, input int aw);
        return i * aw;
    endfunction

    // Low bit of read port i inside the packed data bus
    function automatic int port_data(input int i, input int dw);
        return i * dw;
    endfunction

    // Ceiling log2; log2(DEPTH+1) gives the width needed to count 0..DEPTH
    function automatic int log2(input int v);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++)
            if ((1 << b) < v) r = b + 1;
        return r;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, reservation acceptance
// and a running count of outstanding reservations.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1,
    localparam int DEPTH   = 2 ** ADDR_W,
    localparam int CNT_W   = log2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    output logic [DEPTH-1:0]  pend_vec,
    output logic [CNT_W-1:0]  pend_cnt
);

    logic rsv_zero, wr_zero, rsv_set, wr_clr, inc, dec;

    assign rsv_zero = (ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_IDX));
    assign wr_zero  = (ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_IDX));

    // A write landing on the same register this cycle frees it for the new producer
    assign rsv_ok  = rsv_en && (rsv_zero || !pend_vec[rsv_addr] ||
                                (wr_en && wr_addr == rsv_addr));
    assign rsv_set = rsv_ok && !rsv_zero;
    assign wr_clr  = wr_en && !wr_zero;

    assign inc = rsv_set && !pend_vec[rsv_addr];
    assign dec = wr_clr && pend_vec[wr_addr] && !(rsv_set && rsv_addr == wr_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vec <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_clr)  pend_vec[wr_addr]  <= 1'b0;
            if (rsv_set) pend_vec[rsv_addr] <= 1'b1;
            pend_cnt <= pend_cnt + CNT_W'(inc) - CNT_W'(dec);
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk)
        if (!rst) assert (pend_cnt == CNT_W'($countones(pend_vec)));
`endif

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write-to-read bypass and an
// integrated pending-write scoreboard for the hazard unit.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int DEPTH   = 2 ** ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pending,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok,
    output logic [DEPTH-1:0]         pend_vec,
    output logic [ADDR_W:0]          pend_cnt
);

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic                         wr_real;

    assign wr_real = wr_en && !((ZERO_REG != 0) && (wr_addr == ADDR_W'(ZERO_IDX)));

    always_ff @(posedge clk) begin
        if (rst)          mem <= '0;
        else if (wr_real) mem[wr_addr] <= wr_data;
    end

`ifdef SIM_TRACE
    always @(posedge clk)
        if (!rst && wr_real) $display("regfile_sb: R%0d <= %h", wr_addr, wr_data);
`endif

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .pend_vec (pend_vec),
        .pend_cnt (pend_cnt)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              p;

        assign a = rd_addr[port_addr(i, ADDR_W) +: ADDR_W];

        // Zero register beats bypass so a stray write to R0 never leaks through
        always_comb begin
            d = mem[a];
            p = pend_vec[a];
            if ((ZERO_REG != 0) && (a == ADDR_W'(ZERO_IDX))) begin
                d = '0;
                p = 1'b0;
            end else if ((BYPASS != 0) && wr_en && (wr_addr == a)) begin
                d = wr_data;
                p = 1'b0;
            end
        end

        assign rd_data[port_data(i, DATA_W) +: DATA_W] = d;
        assign rd_pending[i] = p;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed plus random bench for regfile_sb, checked every cycle against an
// array-based reference model; a BYPASS=0 instance runs alongside.
module tb_regfile_sb;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 8;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_RD*ADDR_W-1:0] rd_addr = '0;
    logic [NUM_RD*DATA_W-1:0] rd_data, nb_rd_data;
    logic [NUM_RD-1:0]        rd_pending, nb_rd_pending;
    logic                     wr_en = 1'b0;
    logic [ADDR_W-1:0]        wr_addr = '0;
    logic [DATA_W-1:0]        wr_data = '0;
    logic                     rsv_en = 1'b0;
    logic [ADDR_W-1:0]        rsv_addr = '0;
    logic                     rsv_ok, nb_rsv_ok;
    logic [DEPTH-1:0]         pend_vec, nb_pend_vec;
    logic [ADDR_W:0]          pend_cnt, nb_pend_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                 .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_pending(rd_pending), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(rsv_ok), .pend_vec(pend_vec), .pend_cnt(pend_cnt));

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                 .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nb_rd_data),
        .rd_pending(nb_rd_pending), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(nb_rsv_ok), .pend_vec(nb_pend_vec), .pend_cnt(nb_pend_cnt));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain arrays updated by the architectural rules
    logic [DATA_W-1:0] m_reg [DEPTH];
    bit                m_pend[DEPTH];
    bit                m_valid = 0;
    bit                m_ok;

    function automatic bit m_rsv_ok();
        return rsv_en && (rsv_addr == 0 || !m_pend[rsv_addr] ||
                          (wr_en && wr_addr == rsv_addr));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                m_reg[r]  = '0;
                m_pend[r] = 0;
            end
            m_valid = 1;
        end else if (m_valid) begin
            m_ok = m_rsv_ok();
            if (wr_en && wr_addr != 0) begin
                m_reg[wr_addr]  = wr_data;
                m_pend[wr_addr] = 0;
            end
            if (m_ok && rsv_addr != 0) m_pend[rsv_addr] = 1;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] ed, nd;
            logic              ep, np;
            logic [DEPTH-1:0]  ev;
            int                ec;
            for (int p = 0; p < NUM_RD; p++) begin
                a = rd_addr[p*ADDR_W +: ADDR_W];
                if (a == 0) begin
                    ed = '0; ep = 0; nd = '0; np = 0;
                end else begin
                    nd = m_reg[a]; np = m_pend[a];
                    if (wr_en && wr_addr == a) begin ed = wr_data; ep = 0; end
                    else begin ed = m_reg[a]; ep = m_pend[a]; end
                end
                chk($sformatf("model_rd_data%0d", p), 32'(rd_data[p*DATA_W +: DATA_W]), 32'(ed));
                chk($sformatf("model_rd_pend%0d", p), 32'(rd_pending[p]), 32'(ep));
                chk($sformatf("model_nb_rd_data%0d", p), 32'(nb_rd_data[p*DATA_W +: DATA_W]), 32'(nd));
                chk($sformatf("model_nb_rd_pend%0d", p), 32'(nb_rd_pending[p]), 32'(np));
            end
            ec = 0;
            for (int r = 0; r < DEPTH; r++) begin
                ev[r] = m_pend[r];
                ec += int'(m_pend[r]);
            end
            chk("model_rsv_ok", 32'(rsv_ok), 32'(m_rsv_ok()));
            chk("model_pend_vec", 32'(pend_vec), 32'(ev));
            chk("model_pend_cnt", 32'(pend_cnt), 32'(ec));
            chk("nb_pend_cnt", 32'(nb_pend_cnt), 32'(ec));
            chk("cnt_popcount", 32'(pend_cnt), 32'($countones(pend_vec)));
        end
    end

    task automatic idle();
        wr_en = 0; rsv_en = 0; rd_addr = '0;
    endtask

    task automatic next();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic rd(input int a1, input int a0);
        rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    task automatic wr(input int a, input logic [DATA_W-1:0] d);
        wr_en = 1; wr_addr = ADDR_W'(a); wr_data = d;
    endtask

    task automatic rsv(input int a);
        rsv_en = 1; rsv_addr = ADDR_W'(a);
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state on every register, both ports
        for (int a = 0; a < DEPTH; a++) begin
            rd(a, a);
            @(negedge clk);
            chk("rst_rd_data", rd_data, 32'h0);
            chk("rst_rd_pend", 32'(rd_pending), 32'h0);
            chk("rst_pend_cnt", 32'(pend_cnt), 32'h0);
            next();
        end

        // Same-cycle read of a register being written
        wr(3, 16'hBEEF); rd(0, 3);
        @(negedge clk);
        chk("byp_r3", 32'(rd_data[15:0]), 32'hBEEF);
        chk("nobyp_r3_now", 32'(nb_rd_data[15:0]), 32'h0);
        next(); rd(0, 3);
        @(negedge clk);
        chk("nobyp_r3_next", 32'(nb_rd_data[15:0]), 32'hBEEF);
        next();

        // Register 0 is hard-wired
        wr(0, 16'h1234); rd(0, 0);
        @(negedge clk);
        chk("r0_wr_byp", 32'(rd_data[15:0]), 32'h0);
        next(); rsv(0);
        @(negedge clk);
        chk("r0_rsv_ok", 32'(rsv_ok), 32'h1);
        next();
        @(negedge clk);
        chk("r0_data", 32'(rd_data[15:0]), 32'h0);
        chk("r0_not_pend", 32'(pend_vec[0]), 32'h0);
        next();

        // Reserve, WAW reject, release
        rsv(5);
        @(negedge clk);
        chk("r5_rsv_ok", 32'(rsv_ok), 32'h1);
        next(); rsv(5); rd(0, 5);
        @(negedge clk);
        chk("r5_pend", 32'(rd_pending[0]), 32'h1);
        chk("r5_cnt1", 32'(pend_cnt), 32'h1);
        chk("r5_waw_rej", 32'(rsv_ok), 32'h0);
        next(); wr(5, 16'h00AA); rd(5, 0);
        @(negedge clk);
        chk("r5_byp_data", 32'(rd_data[31:16]), 32'h00AA);
        chk("r5_byp_pend", 32'(rd_pending[1]), 32'h0);
        chk("r5_cnt_still1", 32'(pend_cnt), 32'h1);
        next(); rd(5, 0);
        @(negedge clk);
        chk("r5_cnt0", 32'(pend_cnt), 32'h0);
        chk("r5_data", 32'(rd_data[31:16]), 32'h00AA);
        chk("r5_vec0", 32'(pend_vec), 32'h0);
        next();

        // Write and re-reserve a pending register in one cycle
        rsv(2);
        next(); rsv(2); wr(2, 16'h0F0F); rd(0, 2);
        @(negedge clk);
        chk("r2_rsv_ok", 32'(rsv_ok), 32'h1);
        chk("r2_byp_data", 32'(rd_data[15:0]), 32'h0F0F);
        chk("r2_byp_pend", 32'(rd_pending[0]), 32'h0);
        chk("r2_cnt_before", 32'(pend_cnt), 32'h1);
        next(); rd(0, 2);
        @(negedge clk);
        chk("r2_vec", 32'(pend_vec), 32'h04);
        chk("r2_cnt_after", 32'(pend_cnt), 32'h1);
        chk("r2_pend", 32'(rd_pending[0]), 32'h1);
        chk("r2_data", 32'(rd_data[15:0]), 32'h0F0F);
        next();

        // Reset clears outstanding reservations and discards a concurrent write
        rsv(1); next();
        rsv(4); next();
        rsv(7); next();
        @(negedge clk);
        chk("multi_cnt4", 32'(pend_cnt), 32'h4);
        chk("multi_vec", 32'(pend_vec), 32'h96);
        @(posedge clk); #1;
        rst = 1; wr(4, 16'h5555);
        next(); rst = 0; rd(0, 4);
        @(negedge clk);
        chk("rstmid_vec", 32'(pend_vec), 32'h0);
        chk("rstmid_cnt", 32'(pend_cnt), 32'h0);
        chk("rstmid_r4", 32'(rd_data[15:0]), 32'h0);
        chk("rstmid_pend", 32'(rd_pending), 32'h0);
        next();

        // Random traffic; the model compare and popcount check run every cycle
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            wr_en    = ($urandom_range(0, 9) < 4);
            wr_addr  = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_data  = DATA_W'($urandom);
            rsv_en   = ($urandom_range(0, 9) < 6);
            rsv_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            rd_addr  = (NUM_RD*ADDR_W)'($urandom);
            @(posedge clk); #1;
        end
        rst = 0;
        idle();
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
